// File: rtl/dna_strand_demapper.sv
// rtl/dna_strand_demapper.sv - demaps a 40-nucleotide ASCII strand into a 64-bit BCH codeword
// One nucleotide per cycle; per-group XOR checks and invalid-character flags.
module dna_strand_demapper #(
  parameter int NUM_OF_NUCLEOTIDES = 40,
  parameter int ASCII_SIZE         = 8,
  parameter int CODEWORD_SIZE      = 64
) (
  input  logic                                     clk,
  input  logic                                     resetN,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic [NUM_OF_NUCLEOTIDES*ASCII_SIZE-1:0] strand_in,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [CODEWORD_SIZE-1:0]                 codeword_out,
  output logic [7:0]                               group_err,
  output logic [5:0]                               invalid_count,
  output logic                                     strand_ok
);

  localparam int STRAND_W = NUM_OF_NUCLEOTIDES * ASCII_SIZE;
  localparam int PAYLOAD  = CODEWORD_SIZE / 2;

  typedef enum logic [1:0] {IDLE = 2'd0, DECODE = 2'd1, DONE = 2'd2} state_t;

  state_t                     state, state_nx;
  logic [STRAND_W-1:0]        shreg;
  logic [5:0]                 cnt;
  logic [CODEWORD_SIZE-1:0]   code, code_nx;
  logic [7:0]                 err, err_nx;
  logic [5:0]                 inv, inv_nx;
  logic [7:0][1:0]            gx, gx_nx;
  logic [ASCII_SIZE-1:0]      nuc;
  logic [1:0]                 sym;
  logic                       bad;
  logic                       is_payload;
  logic                       last;

  assign nuc        = shreg[STRAND_W-1 -: ASCII_SIZE];
  assign is_payload = (cnt < 6'(PAYLOAD));
  assign last       = (cnt == 6'(NUM_OF_NUCLEOTIDES - 1));

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid)  state_nx = DECODE;
      DECODE:  if (last)      state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  always_comb begin
    sym = 2'b00;
    bad = 1'b0;
    case (nuc)
      8'h41:   sym = 2'b00;
      8'h43:   sym = 2'b01;
      8'h47:   sym = 2'b10;
      8'h54:   sym = 2'b11;
      default: bad = 1'b1;
    endcase
  end

  // Payload symbols shift in at the LSB so nucleotide 0 ends up in the MSBs.
  always_comb begin
    code_nx = code;
    err_nx  = err;
    gx_nx   = gx;
    inv_nx  = bad ? inv + 6'd1 : inv;
    if (is_payload) begin
      code_nx             = {code[CODEWORD_SIZE-3:0], sym};
      gx_nx[cnt[4:2]]     = gx[cnt[4:2]] ^ sym;
      if (bad) err_nx[cnt[4:2]] = 1'b1;
    end else if (bad || (gx[cnt[2:0]] != sym)) begin
      err_nx[cnt[2:0]] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      shreg         <= '0;
      cnt           <= '0;
      code          <= '0;
      err           <= '0;
      inv           <= '0;
      gx            <= '0;
      codeword_out  <= '0;
      group_err     <= '0;
      invalid_count <= '0;
      strand_ok     <= 1'b0;
    end else begin
      if (state == IDLE && in_valid) begin
        shreg <= strand_in;
        cnt   <= '0;
        code  <= '0;
        err   <= '0;
        inv   <= '0;
        gx    <= '0;
      end else if (state == DECODE) begin
        shreg <= shreg << ASCII_SIZE;
        cnt   <= cnt + 6'd1;
        code  <= code_nx;
        err   <= err_nx;
        inv   <= inv_nx;
        gx    <= gx_nx;
        if (last) begin
          codeword_out  <= code_nx;
          group_err     <= err_nx;
          invalid_count <= inv_nx;
          strand_ok     <= (inv_nx == 6'd0) && (err_nx == 8'd0);
        end
      end
    end
  end

endmodule

// File: tb/tb_dna_strand_demapper.sv
// tb/tb_dna_strand_demapper.sv - self-checking bench for dna_strand_demapper
// Directed and random strands checked against a behavioural model.
module tb_dna_strand_demapper;

  typedef struct packed {
    logic [63:0] cw;
    logic [7:0]  ge;
    logic [5:0]  ic;
    logic        ok;
  } res_t;

  logic         clk = 1'b0;
  logic         resetN;
  logic         in_valid;
  logic         in_ready;
  logic [319:0] strand_in;
  logic         out_valid;
  logic         out_ready;
  logic [63:0]  codeword_out;
  logic [7:0]   group_err;
  logic [5:0]   invalid_count;
  logic         strand_ok;

  int   n_vec = 0;
  int   n_err = 0;
  res_t prev;
  logic [7:0] acgt [4] = '{8'h41, 8'h43, 8'h47, 8'h54};

  dna_strand_demapper dut (
    .clk(clk), .resetN(resetN), .in_valid(in_valid), .in_ready(in_ready),
    .strand_in(strand_in), .out_valid(out_valid), .out_ready(out_ready),
    .codeword_out(codeword_out), .group_err(group_err),
    .invalid_count(invalid_count), .strand_ok(strand_ok)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [319:0] fill(input logic [7:0] c);
    logic [319:0] s;
    for (int k = 0; k < 40; k++) s[319-8*k -: 8] = c;
    return s;
  endfunction

  function automatic res_t model(input logic [319:0] s);
    res_t r;
    int   sym [40];
    bit   bad [40];
    int   x;
    r = '0;
    for (int k = 0; k < 40; k++) begin
      bad[k] = 0;
      case (s[319-8*k -: 8])
        8'h41:   sym[k] = 0;
        8'h43:   sym[k] = 1;
        8'h47:   sym[k] = 2;
        8'h54:   sym[k] = 3;
        default: begin sym[k] = 0; bad[k] = 1; end
      endcase
      if (bad[k]) r.ic++;
    end
    for (int i = 0; i < 32; i++)
      r.cw = r.cw | (64'(sym[i]) << (62 - 2*i));
    for (int g = 0; g < 8; g++) begin
      x = sym[4*g] ^ sym[4*g+1] ^ sym[4*g+2] ^ sym[4*g+3];
      if (x != sym[32+g] || bad[32+g] || bad[4*g] || bad[4*g+1] || bad[4*g+2] || bad[4*g+3])
        r.ge[g] = 1'b1;
    end
    r.ok = (r.ic == 0) && (r.ge == 0);
    return r;
  endfunction

  function automatic logic [319:0] rand_strand();
    logic [319:0] s;
    int sym [32];
    int r, x;
    for (int i = 0; i < 32; i++) begin
      r = $urandom_range(0, 15);
      sym[i] = r % 4;
      s[319-8*i -: 8] = (r == 0) ? 8'($urandom_range(0, 255)) : acgt[r % 4];
    end
    for (int g = 0; g < 8; g++) begin
      x = sym[4*g] ^ sym[4*g+1] ^ sym[4*g+2] ^ sym[4*g+3];
      r = $urandom_range(0, 7);
      if (r < 6)       s[319-8*(32+g) -: 8] = acgt[x];
      else if (r == 6) s[319-8*(32+g) -: 8] = acgt[$urandom_range(0, 3)];
      else             s[319-8*(32+g) -: 8] = 8'($urandom_range(0, 255));
    end
    return s;
  endfunction

  task automatic check_out(input string tag, input res_t e);
    check({tag, ".cw"}, codeword_out, e.cw);
    check({tag, ".ge"}, 64'(group_err), 64'(e.ge));
    check({tag, ".ic"}, 64'(invalid_count), 64'(e.ic));
    check({tag, ".ok"}, 64'(strand_ok), 64'(e.ok));
  endtask

  // Accepts a strand, checks latency and hold-during-decode, optionally
  // applies backpressure with a second strand pulsing on in_valid.
  task automatic run(input string tag, input logic [319:0] s, input res_t e,
                     input bit bp, input logic [319:0] s2);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    check({tag, ".in_ready"}, 64'(in_ready), 64'd1);
    in_valid  = 1'b1;
    strand_in = s;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    strand_in = {10{$urandom}};
    n = 0;
    do begin
      if (n == 20) begin
        in_valid = 1'b1;
        check({tag, ".hold_cw"}, codeword_out, prev.cw);
        check({tag, ".busy"}, 64'(in_ready), 64'd0);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      n++;
    end while (!out_valid && n < 60);
    check({tag, ".latency"}, 64'(n), 64'd40);
    check_out(tag, e);
    if (bp) begin
      for (int c = 0; c < 10; c++) begin
        in_valid  = c[0];
        strand_in = s2;
        out_ready = 1'b0;
        @(posedge clk); #1;
        check({tag, ".bp_valid"}, 64'(out_valid), 64'd1);
        check({tag, ".bp_ready"}, 64'(in_ready), 64'd0);
        check({tag, ".bp_cw"}, codeword_out, e.cw);
      end
      in_valid = 1'b1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check({tag, ".drop_valid"}, 64'(out_valid), 64'd0);
    check({tag, ".idle_ready"}, 64'(in_ready), 64'd1);
    check({tag, ".idle_hold"}, 64'(group_err), 64'(e.ge));
    prev = e;
  endtask

  initial begin
    logic [319:0] s, s2;
    res_t e;
    int seen;
    resetN    = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    strand_in = '0;
    prev      = '0;
    #12;
    check("rst.in_ready", 64'(in_ready), 64'd1);
    check("rst.out_valid", 64'(out_valid), 64'd0);
    check_out("rst", '0);
    @(negedge clk); resetN = 1'b1;
    @(posedge clk); #1;

    run("all_a", fill(8'h41), '{cw: 64'h0, ge: 8'h00, ic: 6'd0, ok: 1'b1}, 0, '0);

    s = fill(8'h54);
    for (int g = 0; g < 8; g++) s[319-8*(32+g) -: 8] = 8'h41;
    run("all_t", s, '{cw: 64'hFFFF_FFFF_FFFF_FFFF, ge: 8'h00, ic: 6'd0, ok: 1'b1}, 0, '0);

    s = fill(8'h41);
    s[319-8*5 -: 8] = 8'h47;
    run("g_at5", s, '{cw: 64'h0020_0000_0000_0000, ge: 8'h02, ic: 6'd0, ok: 1'b0}, 0, '0);

    s = fill(8'h41);
    s[319 -: 8] = 8'h4E;
    s[7:0]      = 8'h78;
    run("invalid", s, '{cw: 64'h0, ge: 8'h81, ic: 6'd2, ok: 1'b0}, 0, '0);

    s  = rand_strand();
    s2 = rand_strand();
    run("bp_first", s, model(s), 1, s2);
    run("bp_second", s2, model(s2), 0, '0);

    s = fill(8'h00);
    run("all_bad", s, '{cw: 64'h0, ge: 8'hFF, ic: 6'd40, ok: 1'b0}, 0, '0);

    // Reset in the middle of a decode aborts the strand.
    in_valid  = 1'b1;
    strand_in = rand_strand();
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #3;
    resetN = 1'b0;
    #1;
    check("abort.in_ready", 64'(in_ready), 64'd1);
    check("abort.out_valid", 64'(out_valid), 64'd0);
    check_out("abort", '0);
    @(negedge clk); resetN = 1'b1;
    prev = '0;
    seen = 0;
    repeat (45) begin @(posedge clk); #1; seen = seen | int'(out_valid); end
    check("abort.no_valid", 64'(seen), 64'd0);

    for (int t = 0; t < 20; t++) begin
      s = rand_strand();
      e = model(s);
      run($sformatf("rand%0d", t), s, e, 0, '0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dna_strand_demapper.md
Name: dna_strand_demapper

Overview:
- Read-path stage that converts one 40-nucleotide ASCII strand into the 64-bit codeword expected by the BCH(63,39) decoder.
- Sits directly downstream of the top-level read_in port and upstream of the BCH decoder.
- Strand layout: 32 payload nucleotides (2 bits each, 64 bits total) followed by 8 check nucleotides, one per group of 4 payload nucleotides.
- Processes one nucleotide per clock and flags groups that are corrupt or contain invalid characters, so the decoder can weight them.

Parameters:
- NUM_OF_NUCLEOTIDES, 40, strand length in nucleotides; fixed as 32 payload + 8 check.
- ASCII_SIZE, 8, bits per nucleotide character.
- CODEWORD_SIZE, 64, output codeword width; equals 2 × payload nucleotides.

Ports:
- clk  in  1  clock.
- resetN  in  1  reset; asynchronous, active-low.
- in_valid  in  1  strand_in is valid.
- in_ready  out  1  block can accept a strand; high only in IDLE.
- strand_in  in  320  ASCII strand; nucleotide k occupies bits [319-8k:312-8k] (nucleotide 0 is the MSB byte).
- out_valid  out  1  result valid; held high until out_ready.
- out_ready  in  1  downstream accepts the result.
- codeword_out  out  64  demapped payload.
- group_err  out  8  bit g = check mismatch or invalid character in group g.
- invalid_count  out  6  number of non-ACGT characters (0..40).
- strand_ok  out  1  high when invalid_count==0 and group_err==0.

Behaviour:
- Reset (async, resetN=0): state IDLE, nucleotide counter 0; all datapath registers 0; in_ready=1; out_valid=0; codeword_out=0, group_err=0, invalid_count=0, strand_ok=0.
- Symbol map: 'A'(0x41)=00, 'C'(0x43)=01, 'G'(0x47)=10, 'T'(0x54)=11.
  - Any other byte, lowercase included, maps to 00, increments invalid_count, and sets group_err for the group the nucleotide belongs to.
- Payload nucleotide i (0..31) maps to codeword_out[63-2i:62-2i]. It belongs to group i/4.
- Check nucleotide 32+g must equal the XOR of the four 2-bit symbols of payload nucleotides 4g..4g+3.
  - A mismatch sets group_err[g].
  - An invalid check character sets group_err[g] and counts as invalid.
- State machine:
  - IDLE: in_ready=1. On in_valid && in_ready at edge E: capture strand_in into a 320-bit shift register, clear the accumulators and counter, go to DECODE.
  - DECODE: in_ready=0. One nucleotide per cycle, taken from the MSB byte; shift left by 8 each cycle. Nucleotide k is consumed at edge E+1+k.
    - Maintain a running 2-bit XOR per group; it is compared when check nucleotide 32+g is consumed.
    - When the counter reaches 39 (edge E+40), go to DONE.
  - DONE: out_valid=1. Outputs are registered and stable. On out_ready=1 at an edge, go to IDLE (out_valid drops, in_ready rises after that edge).
- Latency: out_valid is high in the cycle following edge E+40, i.e. 40 cycles after acceptance. Throughput is one strand per ≥42 cycles.
- Boundary conditions:
  - in_valid during DECODE/DONE is ignored, and strand_in is not sampled.
  - In DONE, in_ready=0, so a new strand is accepted one cycle after the handshake at the earliest.
  - out_ready outside DONE has no effect.
  - codeword_out, group_err, invalid_count and strand_ok update only on the transition into DONE. They hold their last values through IDLE and DECODE and are never partially visible.
  - resetN asserted mid-DECODE aborts immediately to the reset state. No out_valid is produced for the aborted strand.
  - invalid_count saturates naturally at 40 and fits in 6 bits.

Test Plan:
- Thirty-two 'A' + eight 'A' -> after 40 cycles: codeword_out=64'h0, group_err=8'h00, invalid_count=0, strand_ok=1.
- Thirty-two 'T' + eight 'A' (T^T^T^T=00) -> codeword_out=64'hFFFF_FFFF_FFFF_FFFF, group_err=8'h00, strand_ok=1.
- All-'A' strand with nucleotide 5 replaced by 'G' -> codeword_out=64'h0020_0000_0000_0000, group_err=8'h02, invalid_count=0, strand_ok=0.
- All-'A' strand with nucleotide 0 = 'N' (0x4E) and nucleotide 39 = 'x' -> codeword_out=0, group_err=8'h81, invalid_count=2, strand_ok=0.
- Backpressure: hold out_ready=0 for 10 cycles in DONE while pulsing in_valid -> out_valid and outputs stable, in_ready=0, second strand not taken. Then raise out_ready for 1 cycle -> in_ready=1 on the next cycle and the second strand is accepted.
- Accept a strand, assert resetN=0 at DECODE cycle 20 -> all outputs at reset values, in_ready=1, no out_valid. A fresh strand afterwards decodes correctly with 40-cycle latency.
